// File: rtl/cache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_fill_ctrl
// Miss handler for a 4-way cache with 16-byte lines (8 x 16-bit beats).
// On a hard fault it latches the faulting line and the victim way state. If
// the victim is dirty, it writes that line back to memory first. It then
// fetches the new line into the data RAM, writes the tag for the victim way
// and pulses done. Victim ways are chosen round-robin.
//
// Ports
//   main_clk, main_rst_n    clock, asynchronous active-low reset
//   in_hard_fault           miss request (level, sampled only in IDLE)
//   target_address[30:0]    faulting address, bits [25:4] used
//   in_victim_tag[12:0]     address[25:13] held by the victim way
//   in_victim_dirty         victim line is modified
//   out_way_index[1:0]      round-robin victim way
//   out_tag_write           one-cycle tag write strobe
//   out_busy, out_done      fill in progress / one-cycle completion pulse
//   mem_req/mem_we/mem_addr line request to memory (mem_we=1: write-back)
//   mem_ack                 request accepted
//   mem_rdata/mem_rvalid    fill data beats
//   mem_wdata/mem_wvalid/mem_wready  write-back beat handshake
//   dram_addr/dram_we/dram_wdata/dram_rdata  data RAM port, 1-cycle read
// ---------------------------------------------------------------------------
module cache_fill_ctrl #(
  parameter int LINE_BEATS = 8,
  parameter int WAYS       = 4
) (
  input  logic        main_clk,
  input  logic        main_rst_n,
  input  logic        in_hard_fault,
  input  logic [30:0] target_address,
  input  logic [12:0] in_victim_tag,
  input  logic        in_victim_dirty,
  output logic [1:0]  out_way_index,
  output logic        out_tag_write,
  output logic        out_busy,
  output logic        out_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] mem_wdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [11:0] dram_addr,
  output logic        dram_we,
  output logic [15:0] dram_wdata,
  input  logic [15:0] dram_rdata
);

  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);
  localparam logic [1:0] LAST_WAY  = 2'(WAYS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_RD,
    WB_WR,
    RD_REQ,
    RD_DATA,
    TAG_WR,
    DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_beat;
  logic [1:0]  r_wayCnt;
  logic [21:0] r_lineAddr;
  logic [12:0] r_victimTag;

  logic        r_memReq;
  logic        r_memWe;
  logic [21:0] r_memAddr;
  logic [15:0] r_memWdata;
  logic        r_memWvalid;
  logic [11:0] r_dramAddr;
  logic        r_dramWe;
  logic [15:0] r_dramWdata;
  logic        r_tagWrite;
  logic        r_busy;
  logic        r_done;

  state_t      w_stateNext;
  logic [2:0]  w_beatNext;
  logic        w_startFill;
  logic        w_rdBeat;
  logic [21:0] w_lineSrc;
  logic [12:0] w_tagSrc;
  logic [8:0]  w_index;
  logic        w_unusedAddrBits;

  // Only address bits [25:4] describe a cache line; the rest are ignored.
  assign w_unusedAddrBits = ^{target_address[30:26], target_address[3:0]};

  // In IDLE the request address is taken straight from the inputs, so the
  // first mem_addr is ready in the cycle right after the fault is accepted.
  // Once a fill is running, only the latched copies are used.
  assign w_lineSrc   = (r_state == IDLE) ? target_address[25:4] : r_lineAddr;
  assign w_tagSrc    = (r_state == IDLE) ? in_victim_tag : r_victimTag;
  assign w_index     = r_lineAddr[8:0];
  assign w_startFill = (r_state == IDLE) && in_hard_fault;
  assign w_rdBeat    = (r_state == RD_DATA) && mem_rvalid;

  // Next-state and beat sequencing. The beat wraps back to 0 only when a
  // burst state is left, so it always names the beat being transferred.
  always_comb begin
    w_stateNext = r_state;
    w_beatNext  = r_beat;
    case (r_state)
      IDLE: begin
        w_beatNext = 3'd0;
        if (in_hard_fault)
          w_stateNext = in_victim_dirty ? WB_REQ : RD_REQ;
      end
      WB_REQ: begin
        if (mem_ack) begin
          w_stateNext = WB_RD;
          w_beatNext  = 3'd0;
        end
      end
      WB_RD: w_stateNext = WB_WR;
      WB_WR: begin
        if (r_memWvalid && mem_wready) begin
          if (r_beat == LAST_BEAT) begin
            w_stateNext = RD_REQ;
            w_beatNext  = 3'd0;
          end else begin
            w_stateNext = WB_RD;
            w_beatNext  = r_beat + 3'd1;
          end
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          w_stateNext = RD_DATA;
          w_beatNext  = 3'd0;
        end
      end
      RD_DATA: begin
        if (mem_rvalid) begin
          if (r_beat == LAST_BEAT) begin
            w_stateNext = TAG_WR;
            w_beatNext  = 3'd0;
          end else begin
            w_beatNext = r_beat + 3'd1;
          end
        end
      end
      TAG_WR: w_stateNext = DONE;
      DONE:   w_stateNext = IDLE;
      default: begin
        w_stateNext = IDLE;
        w_beatNext  = 3'd0;
      end
    endcase
  end

  // State, beat, latched miss context and the round-robin victim counter.
  // The victim counter only moves as DONE is left.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_state     <= IDLE;
      r_beat      <= 3'd0;
      r_wayCnt    <= 2'd0;
      r_lineAddr  <= 22'd0;
      r_victimTag <= 13'd0;
    end else begin
      r_state <= w_stateNext;
      r_beat  <= w_beatNext;
      if (w_startFill) begin
        r_lineAddr  <= target_address[25:4];
        r_victimTag <= in_victim_tag;
      end
      if (r_state == DONE)
        r_wayCnt <= (r_wayCnt == LAST_WAY) ? 2'd0 : r_wayCnt + 2'd1;
    end
  end

  // Strobes and status are decoded from the next state and registered, so
  // each one is high for exactly the cycles its state is occupied.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= 22'd0;
      r_tagWrite <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_memReq   <= (w_stateNext == WB_REQ) || (w_stateNext == RD_REQ);
      r_memWe    <= (w_stateNext == WB_REQ);
      if (w_stateNext == WB_REQ)
        r_memAddr <= {w_tagSrc, w_lineSrc[8:0]};
      else if (w_stateNext == RD_REQ)
        r_memAddr <= w_lineSrc;
      else
        r_memAddr <= 22'd0;
      r_tagWrite <= (w_stateNext == TAG_WR);
      r_busy     <= (w_stateNext != IDLE) && (w_stateNext != DONE);
      r_done     <= (w_stateNext == DONE);
    end
  end

  // Write-back path. The RAM address is registered on entry to WB_RD, and
  // the RAM answers one cycle later. The first WB_WR cycle therefore only
  // captures the beat; wvalid is raised after that and held until wready.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_memWvalid <= 1'b0;
      r_memWdata  <= 16'd0;
    end else if (r_state == WB_WR) begin
      if (!r_memWvalid) begin
        r_memWvalid <= 1'b1;
        r_memWdata  <= dram_rdata;
      end else if (mem_wready) begin
        r_memWvalid <= 1'b0;
      end
    end else begin
      r_memWvalid <= 1'b0;
    end
  end

  // Data RAM port. A fill beat is written the cycle after it arrives, at
  // the beat it arrived on. A write-back read address is set up as WB_RD
  // is entered.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_dramAddr  <= 12'd0;
      r_dramWe    <= 1'b0;
      r_dramWdata <= 16'd0;
    end else begin
      r_dramWe <= w_rdBeat;
      if (w_rdBeat) begin
        r_dramAddr  <= {w_index, r_beat};
        r_dramWdata <= mem_rdata;
      end else if (w_stateNext == WB_RD) begin
        r_dramAddr <= {w_index, w_beatNext};
      end
    end
  end

  assign out_way_index = r_wayCnt;
  assign out_tag_write = r_tagWrite;
  assign out_busy      = r_busy;
  assign out_done      = r_done;
  assign mem_req       = r_memReq;
  assign mem_we        = r_memWe;
  assign mem_addr      = r_memAddr;
  assign mem_wdata     = r_memWdata;
  assign mem_wvalid    = r_memWvalid;
  assign dram_addr     = r_dramAddr;
  assign dram_we       = r_dramWe;
  assign dram_wdata    = r_dramWdata;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_ctrl
// Self-checking bench for cache_fill_ctrl. The bench plays three roles:
//   - the memory side: ack delay, wready toggling and rvalid gaps
//   - the data RAM: a synchronous array with 1-cycle read latency
//   - a reference model of the fill
// The model describes one fill in terms of the transfers it must produce:
//   - optional write-back request: {victim tag, index}
//   - the old line contents, in beat order
//   - a read request for the line
//   - eight RAM writes of the received beats
//   - one tag write on the round-robin way, then done
// ---------------------------------------------------------------------------
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        fault;
  logic [30:0] tAddr;
  logic [12:0] vTag;
  logic        vDirty;
  logic [1:0]  way;
  logic        tagWrite, busy, done;
  logic        memReq, memWe;
  logic [21:0] memAddr;
  logic        memAck;
  logic [15:0] memRdata;
  logic        memRvalid;
  logic [15:0] memWdata;
  logic        memWvalid;
  logic        memWready;
  logic [11:0] dramAddr;
  logic        dramWe;
  logic [15:0] dramWdata;
  logic [15:0] dramRdata;

  logic [15:0] ram [0:4095];

  int testsRun    = 0;
  int testsFailed = 0;
  int wayModel    = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.LINE_BEATS(8), .WAYS(4)) dut (
    .main_clk        (clk),
    .main_rst_n      (rstN),
    .in_hard_fault   (fault),
    .target_address  (tAddr),
    .in_victim_tag   (vTag),
    .in_victim_dirty (vDirty),
    .out_way_index   (way),
    .out_tag_write   (tagWrite),
    .out_busy        (busy),
    .out_done        (done),
    .mem_req         (memReq),
    .mem_we          (memWe),
    .mem_addr        (memAddr),
    .mem_ack         (memAck),
    .mem_rdata       (memRdata),
    .mem_rvalid      (memRvalid),
    .mem_wdata       (memWdata),
    .mem_wvalid      (memWvalid),
    .mem_wready      (memWready),
    .dram_addr       (dramAddr),
    .dram_we         (dramWe),
    .dram_wdata      (dramWdata),
    .dram_rdata      (dramRdata)
  );

  // Data RAM model: synchronous read with one cycle of latency,
  // plus a write port.
  always @(posedge clk) begin
    dramRdata <= ram[dramAddr];
    if (dramWe)
      ram[dramAddr] <= dramWdata;
  end

  // Compares one observed value with its expected value and records a
  // failure if they differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks that every output of the controller is zero.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({memReq, memWe, memWvalid, dramWe, tagWrite, busy, done, way}), 32'd0);
    checkOutput({tag, "_memaddr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_dramaddr"}, 32'(dramAddr), 32'd0);
    checkOutput({tag, "_data"}, {memWdata, dramWdata}, 32'd0);
  endtask

  // Runs one miss from fault to done and checks every transfer against the
  // model. Arguments:
  //   ackDelay    cycles mem_req is held before it is acked
  //   bp          adds wready toggling and rvalid on every third cycle
  //   toggle      wiggles the fault inputs while the fill is busy
  //   abortBeat   >= 0: reset is asserted once that many fill beats were sent
  //   keepFault   leaves fault high through the DONE cycle
  task automatic applyStimulus(input logic [30:0] addr, input logic [12:0] tag, input logic dirty,
                               input int ackDelay, input bit bp, input bit toggle,
                               input int abortBeat, input bit keepFault);
    logic [21:0] line;
    logic [8:0]  idx;
    logic [15:0] expWb [8];
    logic [15:0] expRd [8];
    logic        expWe;
    int reqCycles = 0;
    int wbCount   = 0;
    int dwCount   = 0;
    int rvSent    = 0;
    int tagCount  = 0;
    int gapCnt    = 0;
    int cycles    = 0;
    bit wbAcked   = 0;
    bit rdAcked   = 0;
    bit finished  = 0;
    bit aborted   = 0;

    line = addr[25:4];
    idx  = addr[12:4];
    for (int b = 0; b < 8; b++) begin
      expWb[b] = ram[{idx, 3'(b)}];
      expRd[b] = 16'($urandom);
    end

    @(negedge clk);
    fault  = 1'b1;
    tAddr  = addr;
    vTag   = tag;
    vDirty = dirty;

    while (!finished && cycles < 600) begin
      @(negedge clk);
      cycles++;
      memAck    = 1'b0;
      memWready = 1'b0;
      memRvalid = 1'b0;
      memRdata  = 16'($urandom);
      if (toggle) begin
        fault  = (tagCount == 0) ? 1'($urandom) : 1'b0;
        tAddr  = 31'($urandom);
        vTag   = 13'($urandom);
        vDirty = 1'($urandom);
      end else begin
        fault = 1'b0;
      end
      if (cycles == 1) begin
        checkOutput("busy_at_start", 32'(busy), 32'd1);
        checkOutput("way_at_start", 32'(way), 32'(wayModel));
      end

      if (dramWe) begin
        if (dwCount < 8) begin
          checkOutput("dram_waddr", 32'(dramAddr), 32'({idx, 3'(dwCount)}));
          checkOutput("dram_wdata", 32'(dramWdata), 32'(expRd[dwCount]));
        end else begin
          checkOutput("dram_we_count", 32'(dwCount + 1), 32'd8);
        end
        dwCount++;
      end
      if (tagWrite) begin
        tagCount++;
        checkOutput("tag_way", 32'(way), 32'(wayModel));
        checkOutput("tag_after_beats", 32'(dwCount), 32'd8);
      end

      if (done) begin
        checkOutput("done_way", 32'(way), 32'(wayModel));
        checkOutput("done_tag_count", 32'(tagCount), 32'd1);
        checkOutput("done_fill_beats", 32'(dwCount), 32'd8);
        checkOutput("done_wb_beats", 32'(wbCount), dirty ? 32'd8 : 32'd0);
        wayModel = (wayModel + 1) % 4;
        fault    = keepFault;
        finished = 1;
      end else if (abortBeat >= 0 && rdAcked && rvSent == abortBeat) begin
        rstN      = 1'b0;
        fault     = 1'b0;
        #1;
        checkAllZero("abort_reset");
        repeat (3) begin
          @(negedge clk);
          checkOutput("abort_no_tag", 32'(tagWrite), 32'd0);
        end
        checkOutput("abort_way", 32'(way), 32'd0);
        rstN     = 1'b1;
        wayModel = 0;
        aborted  = 1;
        finished = 1;
      end else begin
        // Fill data goes out only after the read request has been acked.
        // Any other rvalid is noise that the controller must ignore.
        if (rdAcked && rvSent < 8) begin
          memRvalid = bp ? (gapCnt % 3 == 2) : 1'($urandom);
          gapCnt++;
          if (memRvalid) begin
            memRdata = expRd[rvSent];
            rvSent++;
          end
        end else begin
          memRvalid = 1'($urandom);
        end

        memWready = bp ? 1'($urandom) : 1'b1;
        if (memWvalid && memWready) begin
          if (wbCount < 8)
            checkOutput("wb_wdata", 32'(memWdata), 32'(expWb[wbCount]));
          else
            checkOutput("wb_count", 32'(wbCount + 1), 32'd8);
          wbCount++;
        end

        if (memReq) begin
          expWe = dirty && !wbAcked;
          checkOutput("req_we", 32'(memWe), 32'(expWe));
          checkOutput("req_addr", 32'(memAddr), expWe ? 32'({tag, idx}) : 32'(line));
          if (!expWe && dirty)
            checkOutput("wb_before_rd", 32'(wbCount), 32'd8);
          reqCycles++;
          if (reqCycles > ackDelay) begin
            memAck    = 1'b1;
            reqCycles = 0;
            if (expWe) wbAcked = 1;
            else       rdAcked = 1;
          end
        end
      end
    end
    checkOutput("fill_finished", 32'(finished), 32'd1);

    if (!aborted && !keepFault) begin
      @(negedge clk);
      memAck    = 1'b0;
      memWready = 1'b0;
      memRvalid = 1'b0;
      checkOutput("busy_cleared", 32'(busy), 32'd0);
      checkOutput("way_advanced", 32'(way), 32'(wayModel));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      ram[i] <= 16'($urandom);
    rstN      = 1'b0;
    fault     = 1'b0;
    tAddr     = '0;
    vTag      = '0;
    vDirty    = 1'b0;
    memAck    = 1'b0;
    memRdata  = '0;
    memRvalid = 1'b0;
    memWready = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Clean miss.
    applyStimulus(31'h0123450, 13'h0091, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0);
    // Dirty miss with index 0x045 and victim tag 0x1ABC.
    applyStimulus({5'd0, 13'h0AB, 9'h045, 4'h0}, 13'h1ABC, 1'b1, 0, 1'b0, 1'b0, -1, 1'b0);
    // Backpressure: ack after 5 cycles, wready toggling, rvalid every third cycle.
    applyStimulus(31'h2F0E5A0, 13'h0777, 1'b1, 5, 1'b1, 1'b0, -1, 1'b0);
    // Reset at fill beat 4, then a fresh fill.
    applyStimulus(31'h15A5A50, 13'h1234, 1'b1, 1, 1'b0, 1'b0, 4, 1'b0);
    // Four back-to-back fills; fault held through DONE. Ways go 0,1,2,3, then 0.
    for (int k = 0; k < 4; k++)
      applyStimulus(31'($urandom), 13'($urandom), 1'($urandom), 0, 1'b0, 1'b0, -1, (k < 3));
    // Fault inputs wiggled during a busy fill.
    applyStimulus(31'h0ABCDE0, 13'h0C3C, 1'b1, 2, 1'b1, 1'b1, -1, 1'b0);
    // Random misses.
    for (int k = 0; k < 6; k++)
      applyStimulus(31'($urandom), 13'($urandom), 1'($urandom), $urandom_range(0, 4),
                    1'($urandom), 1'($urandom), -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
